// File: rtl/config_stream_loader.sv
// Upstream driver of the tile configuration chain: clears the chain, then serialises host words
// MSB-first onto it. Define CONFIG_LOADER_CRC_EN to add a CRC-8 check word after the last chain bit.
module config_stream_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 96,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_data_out,
    output logic                  config_enable,
    output logic                  config_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            state_dbg
);
    // Handshake: a word is taken on every rising edge where word_valid && word_ready are both high;
    // word_ready is a registered output and never looks at word_valid in the same cycle.

    localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int WB_W  = $clog2(WORD_WIDTH + 1);
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_WIDTH - 1);
    localparam logic [CLR_W-1:0] LAST_CLR  = CLR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3
`ifdef CONFIG_LOADER_CRC_EN
        , S_CHECK = 3'd4
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]       word_bit_q, word_bit_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic                  done_q, done_d;
    logic                  word_ready_q, word_ready_d;
    logic                  config_data_q, config_data_d;
    logic                  config_enable_q, config_enable_d;
    logic                  config_nreset_q, config_nreset_d;
    logic                  busy_q, busy_d;
    logic                  take_word;

    assign take_word = word_valid && word_ready_q;

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       error_q, error_d;

    // Bit-serial CRC-8, polynomial x^8+x^2+x+1, non-reflected.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_bit_d = word_bit_q;
        shreg_d    = shreg_q;
        done_d     = done_q;
`ifdef CONFIG_LOADER_CRC_EN
        crc_d      = crc_q;
        error_d    = error_q;
`endif
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_CLEAR;
                        clr_cnt_d = '0;
                        done_d    = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
                        error_d   = 1'b0;
`endif
                    end
                end
                S_CLEAR: begin
                    bit_cnt_d  = '0;
                    word_bit_d = '0;
`ifdef CONFIG_LOADER_CRC_EN
                    crc_d      = 8'h00;
`endif
                    if (clr_cnt_q == LAST_CLR) begin
                        state_d = S_LOAD;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (take_word) begin
                        shreg_d    = word_data;
                        word_bit_d = '0;
                        state_d    = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // shreg_q MSB is the bit on config_data_out this cycle
                    shreg_d    = {shreg_q[WORD_WIDTH-2:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    word_bit_d = word_bit_q + 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                    crc_d      = crc8_step(crc_q, shreg_q[WORD_WIDTH-1]);
`endif
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef CONFIG_LOADER_CRC_EN
                        state_d = S_CHECK;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end else if (word_bit_q == LAST_WBIT) begin
                        state_d = S_LOAD;
                    end
                end
`ifdef CONFIG_LOADER_CRC_EN
                S_CHECK: begin
                    if (take_word) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        error_d = (word_data[7:0] != crc_q);
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a plain flop
    always_comb begin
        word_ready_d    = (state_d == S_LOAD);
`ifdef CONFIG_LOADER_CRC_EN
        word_ready_d    = word_ready_d || (state_d == S_CHECK);
`endif
        config_enable_d = (state_d == S_SHIFT);
        config_data_d   = config_enable_d && shreg_d[WORD_WIDTH-1];
        config_nreset_d = (state_d != S_CLEAR);
        busy_d          = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            word_bit_q      <= '0;
            shreg_q         <= '0;
            done_q          <= 1'b0;
            word_ready_q    <= 1'b0;
            config_data_q   <= 1'b0;
            config_enable_q <= 1'b0;
            config_nreset_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            clr_cnt_q       <= clr_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            word_bit_q      <= word_bit_d;
            shreg_q         <= shreg_d;
            done_q          <= done_d;
            word_ready_q    <= word_ready_d;
            config_data_q   <= config_data_d;
            config_enable_q <= config_enable_d;
            config_nreset_q <= config_nreset_d;
            busy_q          <= busy_d;
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q   <= 8'h00;
            error_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign word_ready      = word_ready_q;
    assign config_data_out = config_data_q;
    assign config_enable   = config_enable_q;
    assign config_nreset   = config_nreset_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign state_dbg       = state_q;

endmodule
